// File: rtl/uart_tx_arb_if.sv
// Bundles requester pushes, transmitter handshake and status for the two-requester UART TX arbiter.
// Latency: none (wiring only).
// Backpressure: reqN_ready from the arbiter throttles each requester; tx_busy throttles the arbiter.
interface uart_tx_arb_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          req0_valid;
    logic [7:0]    req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [7:0]    req1_data;
    logic          req1_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          grant_id;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    // Requesters and transmitter side: drives bytes and busy, observes status.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_data, tx_start, grant_id, count0, count1
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_data, tx_start, grant_id, count0, count1
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Byte FIFO with wrap-around pointers; head byte visible combinationally.
// Latency: a pushed byte is visible at the head one cycle after the push edge.
// Backpressure: push_rdy drops when full, decoded from the registered count only.
module uart_tx_arb_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [7:0]    push_dat,
    output logic          push_rdy,
    input  logic          pop,
    output logic [7:0]    head_dat,
    output logic [CW-1:0] count
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and fill-level bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Two-requester round-robin arbiter feeding one byte at a time to a UART transmitter.
// Latency: byte pushed at edge n into an idle arbiter gives tx_start in the cycle after edge n+1.
// Backpressure: per-requester FIFO ready; a new byte is issued only after tx_busy rises and falls.
module uart_tx_arb #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         CLK,
    input  logic         reset,
    uart_tx_arb_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          issue;
    logic          sel;
    logic          start_pulse;
    logic          pop0;
    logic          pop1;
    logic [7:0]    head0;
    logic [7:0]    head1;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          rdy0;
    logic          rdy1;
    logic          ne0;
    logic          ne1;
    logic [7:0]    tx_data_q;
    logic          grant_q;

    uart_tx_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk      (CLK),
        .rst      (reset),
        .push_vld (bus.req0_valid),
        .push_dat (bus.req0_data),
        .push_rdy (rdy0),
        .pop      (pop0),
        .head_dat (head0),
        .count    (cnt0)
    );

    uart_tx_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk      (CLK),
        .rst      (reset),
        .push_vld (bus.req1_valid),
        .push_dat (bus.req1_data),
        .push_rdy (rdy1),
        .pop      (pop1),
        .head_dat (head1),
        .count    (cnt1)
    );

    assign ne0  = (cnt0 != '0);
    assign ne1  = (cnt1 != '0);
    assign pop0 = issue && !sel;
    assign pop1 = issue && sel;

    // State register; reset aborts any frame in flight without waiting on tx_busy.
    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, grant selection and the one-cycle start pulse.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        sel         = 1'b0;
        start_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.tx_busy && (ne0 || ne1)) begin
                    issue     = 1'b1;
                    // On a tie, alternate away from the last winner.
                    sel       = (ne0 && ne1) ? !grant_q : ne1;
                    state_nxt = START;
                end
            end
            START: begin
                start_pulse = 1'b1;
                state_nxt   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the popped byte and the winner; both hold until the next issue.
    always_ff @(posedge CLK) begin
        if (reset) begin
            tx_data_q <= 8'h00;
            grant_q   <= 1'b1;
        end else if (issue) begin
            tx_data_q <= sel ? head1 : head0;
            grant_q   <= sel;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.count0     = cnt0;
    assign bus.count1     = cnt1;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = start_pulse;
    assign bus.grant_id   = grant_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a scoreboard of expected issued bytes.
// Latency: checks first-issue timing and post-reset timing explicitly.
// Backpressure: a transmitter model drives tx_busy; a manual busy override stalls the arbiter.
module tb_uart_tx_arb;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [7:0] dat;
        logic       gid;
    } exp_t;

    logic CLK = 1'b0;
    logic reset;
    logic model_busy  = 1'b0;
    logic manual_busy = 1'b0;
    logic model_en    = 1'b0;
    int   busy_delay  = 0;
    int   busy_len    = 10;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   starts = 0;
    logic outstanding = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_arb_if #(.FIFO_DEPTH(FIFO_DEPTH)) ifc ();

    uart_tx_arb #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (ifc)
    );

    assign ifc.tx_busy = model_busy | manual_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic g);
        exp_q.push_back('{dat: d, gid: g});
    endtask

    task automatic push0(input logic [7:0] d);
        ifc.req0_valid = 1'b1;
        ifc.req0_data  = d;
        step();
        ifc.req0_valid = 1'b0;
    endtask

    task automatic push_both(input logic [7:0] a, input logic [7:0] b);
        ifc.req0_valid = 1'b1;
        ifc.req0_data  = a;
        ifc.req1_valid = 1'b1;
        ifc.req1_data  = b;
        step();
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || ifc.tx_busy || outstanding) && cyc < 400) begin
            step();
            cyc++;
        end
        check("drain_in_time", (cyc < 400), 1);
        repeat (3) step();
    endtask

    // Transmitter model: busy rises busy_delay cycles after tx_start, lasts busy_len cycles.
    initial begin
        forever begin
            @(negedge CLK);
            if (model_en && ifc.tx_start && !reset) begin
                repeat (busy_delay) @(negedge CLK);
                model_busy = 1'b1;
                repeat (busy_len) @(negedge CLK);
                model_busy = 1'b0;
            end
        end
    end

    // Output monitor: compares every issued byte with the scoreboard head.
    initial begin
        exp_t e;
        logic prev_busy  = 1'b0;
        logic prev_start = 1'b0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                outstanding = 1'b0;
                prev_start  = 1'b0;
            end else begin
                if (prev_busy && !ifc.tx_busy) outstanding = 1'b0;
                if (ifc.tx_start) begin
                    starts++;
                    check("start_one_cycle", prev_start, 0);
                    check("one_outstanding", outstanding, 0);
                    check("start_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("issued_data", ifc.tx_data, e.dat);
                        check("issued_grant", ifc.grant_id, e.gid);
                    end
                    outstanding = 1'b1;
                end
                prev_start = ifc.tx_start;
            end
            prev_busy = ifc.tx_busy;
        end
    end

    initial begin
        int s0;
        reset          = 1'b1;
        ifc.req0_valid = 1'b0;
        ifc.req0_data  = 8'h00;
        ifc.req1_valid = 1'b0;
        ifc.req1_data  = 8'h00;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_ready0", ifc.req0_ready, 1);
        check("rst_ready1", ifc.req1_ready, 1);
        check("rst_count0", ifc.count0, 0);
        check("rst_count1", ifc.count1, 0);
        check("rst_tx_start", ifc.tx_start, 0);
        check("rst_tx_data", ifc.tx_data, 8'h00);
        check("rst_grant", ifc.grant_id, 1);

        // Single byte and first-issue latency
        model_en = 1'b1;
        s0 = starts;
        expect_byte(8'h41, 1'b0);
        push0(8'h41);
        check("single_count_after_push", ifc.count0, 1);
        check("latency_edge_n", ifc.tx_start, 0);
        step();
        check("latency_edge_n1", ifc.tx_start, 1);
        check("single_tx_data", ifc.tx_data, 8'h41);
        check("single_grant", ifc.grant_id, 0);
        check("single_count_after_pop", ifc.count0, 0);
        wait_drain();
        check("single_pulse_count", starts - s0, 1);
        check("single_data_held", ifc.tx_data, 8'h41);

        // Contention from a fresh reset: requester 0 wins the first tie
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_grant_after_reset", ifc.grant_id, 1);
        manual_busy = 1'b1;
        expect_byte(8'hA0, 1'b0);
        expect_byte(8'hB0, 1'b1);
        expect_byte(8'hA1, 1'b0);
        expect_byte(8'hB1, 1'b1);
        push_both(8'hA0, 8'hB0);
        push_both(8'hA1, 8'hB1);
        check("rr_preload_count0", ifc.count0, 2);
        check("rr_preload_count1", ifc.count1, 2);
        manual_busy = 1'b0;
        wait_drain();

        // Full FIFO: fifth byte must be refused
        manual_busy = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check("full_ready_before", ifc.req0_ready, 1);
            expect_byte(8'hC0 + 8'(i), 1'b0);
            push0(8'hC0 + 8'(i));
        end
        check("full_ready_after_4", ifc.req0_ready, 0);
        check("full_count_4", ifc.count0, 4);
        push0(8'hC4);
        check("full_count_stays_4", ifc.count0, 4);
        check("full_ready_stays_0", ifc.req0_ready, 0);
        manual_busy = 1'b0;
        wait_drain();

        // Simultaneous push and pop at count 2
        manual_busy = 1'b1;
        expect_byte(8'hD0, 1'b0);
        expect_byte(8'hD1, 1'b0);
        push0(8'hD0);
        push0(8'hD1);
        check("simul_count_before", ifc.count0, 2);
        manual_busy = 1'b0;
        expect_byte(8'hD2, 1'b0);
        push0(8'hD2);
        check("simul_count_kept", ifc.count0, 2);
        check("simul_tx_data", ifc.tx_data, 8'hD0);
        wait_drain();

        // Slow transmitter: busy rises 3 cycles after tx_start
        busy_delay = 3;
        s0 = starts;
        expect_byte(8'hF0, 1'b1);
        expect_byte(8'hE0, 1'b0);
        push_both(8'hE0, 8'hF0);
        wait_drain();
        check("slow_pulse_count", starts - s0, 2);
        busy_delay = 0;

        // Reset while waiting for the frame to finish
        model_en = 1'b0;
        expect_byte(8'h60, 1'b0);
        push0(8'h60);
        push0(8'h61);
        manual_busy = 1'b1;
        step();
        step();
        step();
        check("abort_count_before", ifc.count0, 1);
        reset          = 1'b1;
        ifc.req0_valid = 1'b1;
        ifc.req0_data  = 8'h99;
        step();
        reset          = 1'b0;
        ifc.req0_valid = 1'b0;
        check("abort_count0", ifc.count0, 0);
        check("abort_count1", ifc.count1, 0);
        check("abort_ready0", ifc.req0_ready, 1);
        check("abort_ready1", ifc.req1_ready, 1);
        check("abort_tx_start", ifc.tx_start, 0);
        check("abort_tx_data", ifc.tx_data, 8'h00);
        check("abort_grant", ifc.grant_id, 1);
        model_en = 1'b1;
        expect_byte(8'h5A, 1'b0);
        push0(8'h5A);
        step();
        check("abort_waits_for_idle_busy", ifc.tx_start, 0);
        manual_busy = 1'b0;
        step();
        check("abort_back_in_idle", ifc.tx_start, 1);
        wait_drain();

        check("scoreboard_empty", exp_q.size(), 0);
        check("final_count0", ifc.count0, 0);
        check("final_count1", ifc.count1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
